// File: rtl/banked_stream_ub.sv
// Unified buffer for raster-order streaming: cyclically banked storage where each bank
// is a circular FIFO with its own pointers and occupancy, plus a registered read port.
module banked_stream_ub #(
    parameter int WIDTH      = 16,
    parameter int EXT_X      = 64,
    parameter int EXT_Y      = 64,
    parameter int BANKS_X    = 2,
    parameter int BANKS_Y    = 2,
    parameter int BANK_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    output logic             wready,
    output logic [15:0]      wr_x,
    output logic [15:0]      wr_y,
    output logic             wr_done,
    input  logic             ren,
    output logic             rempty,
    output logic [15:0]      rd_x,
    output logic [15:0]      rd_y,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             rd_done,
    output logic [15:0]      count
);

    localparam int NB = BANKS_X * BANKS_Y;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = $clog2(BANK_DEPTH);
    localparam int OW = $clog2(BANK_DEPTH + 1);

    logic [WIDTH-1:0] r_mem  [NB][BANK_DEPTH];
    logic [PW-1:0]    r_wptr [NB];
    logic [PW-1:0]    r_rptr [NB];
    logic [OW-1:0]    r_occ  [NB];

    logic [15:0]      r_wr_x, r_wr_y, r_rd_x, r_rd_y, r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid, r_wr_done, r_rd_done;

    logic [BW-1:0]    w_wbank, w_rbank;
    logic             w_wready, w_rempty, w_wr, w_rd, w_wlast, w_rlast;
    logic [15:0]      w_wr_x_nxt, w_wr_y_nxt, w_rd_x_nxt, w_rd_y_nxt;

    function automatic logic [BW-1:0] bank_of(input logic [15:0] x, input logic [15:0] y);
        int unsigned b;
        b = (32'(x) % BANKS_X) + BANKS_X * (32'(y) % BANKS_Y);
        return BW'(b);
    endfunction

    assign w_wbank  = bank_of(r_wr_x, r_wr_y);
    assign w_rbank  = bank_of(r_rd_x, r_rd_y);
    assign w_wready = r_occ[w_wbank] < OW'(BANK_DEPTH);
    assign w_rempty = (r_occ[w_rbank] == '0);
    assign w_wr     = wen && w_wready;
    assign w_rd     = ren && !w_rempty;
    assign w_wlast  = (r_wr_x == 16'(EXT_X - 1)) && (r_wr_y == 16'(EXT_Y - 1));
    assign w_rlast  = (r_rd_x == 16'(EXT_X - 1)) && (r_rd_y == 16'(EXT_Y - 1));

    always_comb begin
        w_wr_x_nxt = r_wr_x + 16'd1;
        w_wr_y_nxt = r_wr_y;
        if (r_wr_x == 16'(EXT_X - 1)) begin
            w_wr_x_nxt = '0;
            w_wr_y_nxt = (r_wr_y == 16'(EXT_Y - 1)) ? '0 : r_wr_y + 16'd1;
        end
        w_rd_x_nxt = r_rd_x + 16'd1;
        w_rd_y_nxt = r_rd_y;
        if (r_rd_x == 16'(EXT_X - 1)) begin
            w_rd_x_nxt = '0;
            w_rd_y_nxt = (r_rd_y == 16'(EXT_Y - 1)) ? '0 : r_rd_y + 16'd1;
        end
    end

    // Storage is deliberately untouched by rst/flush; only pointers and counters clear.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_wr)
            r_mem[w_wbank][r_wptr[w_wbank]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_x    <= '0;
            r_wr_y    <= '0;
            r_rd_x    <= '0;
            r_rd_y    <= '0;
            r_count   <= '0;
            r_rvalid  <= 1'b0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_wptr    <= '{default: '0};
            r_rptr    <= '{default: '0};
            r_occ     <= '{default: '0};
            if (rst)
                r_rdata <= '0;
        end else begin
            if (w_wr) begin
                r_wptr[w_wbank] <= r_wptr[w_wbank] + PW'(1);
                r_wr_x          <= w_wr_x_nxt;
                r_wr_y          <= w_wr_y_nxt;
            end
            r_wr_done <= w_wr && w_wlast;

            if (w_rd) begin
                r_rptr[w_rbank] <= r_rptr[w_rbank] + PW'(1);
                r_rd_x          <= w_rd_x_nxt;
                r_rd_y          <= w_rd_y_nxt;
                r_rdata         <= r_mem[w_rbank][r_rptr[w_rbank]];
            end
            r_rvalid  <= w_rd;
            r_rd_done <= w_rd && w_rlast;

            // A write and a read hitting the same bank cancel out in its occupancy.
            for (int unsigned b = 0; b < NB; b++) begin
                r_occ[b] <= r_occ[b]
                          + OW'(w_wr && (w_wbank == BW'(b)))
                          - OW'(w_rd && (w_rbank == BW'(b)));
            end

            if (w_wr && !w_rd)
                r_count <= r_count + 16'd1;
            else if (!w_wr && w_rd)
                r_count <= r_count - 16'd1;
        end
    end

    assign wready  = w_wready;
    assign rempty  = w_rempty;
    assign wr_x    = r_wr_x;
    assign wr_y    = r_wr_y;
    assign rd_x    = r_rd_x;
    assign rd_y    = r_rd_y;
    assign wr_done = r_wr_done;
    assign rd_done = r_rd_done;
    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign count   = r_count;

endmodule

// File: tb/tb_banked_stream_ub.sv
// Bench for banked_stream_ub: two instances (bank depth 4 and 2) share one stimulus and are
// checked every cycle against a sequence-number model of the raster stream.
module tb_banked_stream_ub;

    localparam int W  = 16;
    localparam int EX = 4;
    localparam int EY = 4;
    localparam int FR = EX * EY;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush, wen, ren;
    logic [W-1:0] wdata;

    logic         wready [2], rempty [2], wr_done [2], rd_done [2], rvalid [2];
    logic [15:0]  wr_x [2], wr_y [2], rd_x [2], rd_y [2], count [2];
    logic [W-1:0] rdata [2];

    banked_stream_ub #(.WIDTH(W), .EXT_X(EX), .EXT_Y(EY), .BANKS_X(2), .BANKS_Y(2), .BANK_DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wdata(wdata),
        .wready(wready[0]), .wr_x(wr_x[0]), .wr_y(wr_y[0]), .wr_done(wr_done[0]),
        .ren(ren), .rempty(rempty[0]), .rd_x(rd_x[0]), .rd_y(rd_y[0]),
        .rdata(rdata[0]), .rvalid(rvalid[0]), .rd_done(rd_done[0]), .count(count[0])
    );

    banked_stream_ub #(.WIDTH(W), .EXT_X(EX), .EXT_Y(EY), .BANKS_X(2), .BANKS_Y(2), .BANK_DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wdata(wdata),
        .wready(wready[1]), .wr_x(wr_x[1]), .wr_y(wr_y[1]), .wr_done(wr_done[1]),
        .ren(ren), .rempty(rempty[1]), .rd_x(rd_x[1]), .rd_y(rd_y[1]),
        .rdata(rdata[1]), .rvalid(rvalid[1]), .rd_done(rd_done[1]), .count(count[1])
    );

    // Model: wn/rn count elements written/read since the last clear; element k sits at
    // raster index k % FR, so coordinates, occupancy and bank fullness follow directly.
    int           depth [2] = '{4, 2};
    int           wn [2] = '{0, 0};
    int           rn [2] = '{0, 0};
    logic [W-1:0] mq [2][4096];
    logic [W-1:0] e_rdata [2] = '{'0, '0};
    logic         e_rvalid [2] = '{1'b0, 1'b0};
    logic         e_wrd [2] = '{1'b0, 1'b0};
    logic         e_rdd [2] = '{1'b0, 1'b0};

    int ntests = 0;
    int nfail  = 0;

    function automatic int bank_at(int k);
        int x = (k % FR) % EX;
        int y = (k % FR) / EX;
        return (x % 2) + 2 * (y % 2);
    endfunction

    function automatic int occ_of(int m, int b);
        int c = 0;
        for (int i = rn[m]; i < wn[m]; i++)
            if (bank_at(i) == b) c++;
        return c;
    endfunction

    function automatic bit m_wready(int m);
        return occ_of(m, bank_at(wn[m])) < depth[m];
    endfunction

    function automatic bit m_rempty(int m);
        return wn[m] == rn[m];
    endfunction

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            bit aw, ar;
            aw = wen && m_wready(m);
            ar = ren && !m_rempty(m);
            if (rst) begin
                wn[m] = 0; rn[m] = 0;
                e_rvalid[m] = 1'b0; e_rdata[m] = '0; e_wrd[m] = 1'b0; e_rdd[m] = 1'b0;
            end else if (flush) begin
                wn[m] = 0; rn[m] = 0;
                e_rvalid[m] = 1'b0; e_wrd[m] = 1'b0; e_rdd[m] = 1'b0;
            end else begin
                e_rvalid[m] = ar;
                e_rdd[m]    = ar && (rn[m] % FR == FR - 1);
                if (ar) begin
                    e_rdata[m] = mq[m][rn[m] % 4096];
                    rn[m]++;
                end
                e_wrd[m] = aw && (wn[m] % FR == FR - 1);
                if (aw) begin
                    mq[m][wn[m] % 4096] = wdata;
                    wn[m]++;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s[depth%0d] observed=%0h expected=%0h", tag, depth[m], obs, exp);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            chk("wready",  m, 32'(wready[m]),  32'(m_wready(m)));
            chk("rempty",  m, 32'(rempty[m]),  32'(m_rempty(m)));
            chk("wr_x",    m, 32'(wr_x[m]),    32'((wn[m] % FR) % EX));
            chk("wr_y",    m, 32'(wr_y[m]),    32'((wn[m] % FR) / EX));
            chk("rd_x",    m, 32'(rd_x[m]),    32'((rn[m] % FR) % EX));
            chk("rd_y",    m, 32'(rd_y[m]),    32'((rn[m] % FR) / EX));
            chk("count",   m, 32'(count[m]),   32'(wn[m] - rn[m]));
            chk("rvalid",  m, 32'(rvalid[m]),  32'(e_rvalid[m]));
            chk("rdata",   m, 32'(rdata[m]),   32'(e_rdata[m]));
            chk("wr_done", m, 32'(wr_done[m]), 32'(e_wrd[m]));
            chk("rd_done", m, 32'(rd_done[m]), 32'(e_rdd[m]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    logic [W-1:0] hist [64];

    initial begin
        rst = 1'b1; flush = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
        cyc(); cyc();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk("rst_wready", m, 32'(wready[m]), 32'd1);
            chk("rst_rempty", m, 32'(rempty[m]), 32'd1);
            chk("rst_rvalid", m, 32'(rvalid[m]), 32'd0);
            chk("rst_rdata",  m, 32'(rdata[m]),  32'd0);
            chk("rst_count",  m, 32'(count[m]),  32'd0);
        end

        // Fill a frame with no reads: depth 4 takes all 16, depth 2 stalls at (0,2).
        wen = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = W'(i);
            cyc();
        end
        wen = 1'b0;
        chk("fill_wr_done", 0, 32'(wr_done[0]), 32'd1);
        chk("fill_count",   0, 32'(count[0]),   32'd16);
        chk("fill_wready",  0, 32'(wready[0]),  32'd0);
        chk("stall_count",  1, 32'(count[1]),   32'd8);
        chk("stall_wr_x",   1, 32'(wr_x[1]),    32'd0);
        chk("stall_wr_y",   1, 32'(wr_y[1]),    32'd2);
        chk("stall_wready", 1, 32'(wready[1]),  32'd0);

        ren = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("order_rdata",  0, 32'(rdata[0]),  32'(i));
            chk("order_rvalid", 0, 32'(rvalid[0]), 32'd1);
        end
        chk("order_rd_done", 0, 32'(rd_done[0]), 32'd1);
        ren = 1'b0;

        // Reset in the middle of traffic.
        wen = 1'b1;
        for (int i = 0; i < 5; i++) begin wdata = W'($urandom); cyc(); end
        ren = 1'b1;
        for (int i = 0; i < 2; i++) begin wdata = W'($urandom); cyc(); end
        wen = 1'b0; ren = 1'b0; rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk("mid_rst_rdata", m, 32'(rdata[m]), 32'd0);
            chk("mid_rst_count", m, 32'(count[m]), 32'd0);
            chk("mid_rst_rd_x",  m, 32'(rd_x[m]),  32'd0);
        end

        // Steady streaming over 3 frames after a one-cycle lead.
        wen = 1'b1;
        hist[0] = W'($urandom); wdata = hist[0];
        cyc();
        ren = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            hist[k] = W'($urandom); wdata = hist[k];
            cyc();
            for (int m = 0; m < 2; m++) begin
                chk("pipe_count", m, 32'(count[m]), 32'd1);
                chk("pipe_rdata", m, 32'(rdata[m]), 32'(hist[k-1]));
            end
        end
        wen = 1'b0;
        cyc();
        ren = 1'b0;

        // Flush after 6 writes and 2 reads, then a single element round trip.
        wen = 1'b1;
        for (int i = 0; i < 6; i++) begin wdata = W'($urandom); cyc(); end
        wen = 1'b0; ren = 1'b1;
        cyc(); cyc();
        ren = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk("flush_count",  m, 32'(count[m]),  32'd0);
            chk("flush_rempty", m, 32'(rempty[m]), 32'd1);
            chk("flush_rvalid", m, 32'(rvalid[m]), 32'd0);
            chk("flush_wr_x",   m, 32'(wr_x[m]),   32'd0);
            chk("flush_rd_y",   m, 32'(rd_y[m]),   32'd0);
        end
        wen = 1'b1; wdata = 16'h00A5;
        cyc();
        wen = 1'b0; ren = 1'b1;
        cyc();
        for (int m = 0; m < 2; m++) begin
            chk("a5_rdata",  m, 32'(rdata[m]),  32'h00A5);
            chk("a5_rvalid", m, 32'(rvalid[m]), 32'd1);
        end

        // Reads against an empty buffer change nothing.
        for (int i = 0; i < 5; i++) begin
            cyc();
            for (int m = 0; m < 2; m++) begin
                chk("empty_rvalid", m, 32'(rvalid[m]), 32'd0);
                chk("empty_rdata",  m, 32'(rdata[m]),  32'h00A5);
                chk("empty_rd_x",   m, 32'(rd_x[m]),   32'd1);
            end
        end
        ren = 1'b0;

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 500; i++) begin
            wen   = ($urandom_range(0, 3) != 0);
            ren   = ($urandom_range(0, 3) != 0);
            wdata = W'($urandom);
            flush = ($urandom_range(0, 63) == 0);
            rst   = ($urandom_range(0, 127) == 0);
            cyc();
        end
        rst = 1'b0; flush = 1'b0; wen = 1'b0; ren = 1'b0;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
